conv_lb_seq: RTL
================

Name: conv_lb_seq

Overview:
- Sequencer for the chain of line-buffer controllers in the conv datapath.
- Accepts the raw pixel stream (valid + sof/eol tags) and generates the push/pop/sof/eol strobes for the KERNEL_H-1 line buffers.
- Tracks frame geometry (column, row, line width, frame height) and emits a latency-matched window-valid with position tags to the convolution core.
- Detects malformed frames and recovers on the next start-of-frame.

Parameters:
- KERNEL_H, 3, kernel height; number of line buffers LB_N = KERNEL_H-1 (must be >= 2).
- IMAGE_MAX_W, conv_pkg::IMAGE_MAX_W, maximum line width; column counter width CW = $clog2(IMAGE_MAX_W).
- IMAGE_MAX_H, 1024, maximum frame height; row counter width RW = $clog2(IMAGE_MAX_H).
- LB_LAT, 2, line-buffer push-to-column-out latency in cycles (BRAM read + output flop).

Ports:
- clk  in  1  clock.
- arst_n  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- in_vld_i  in  1  pixel valid; no backpressure, every valid beat is consumed or dropped.
- in_sof_i  in  1  first pixel of frame.
- in_eol_i  in  1  last pixel of line.
- cfg_h_i  in  RW  frame height in lines; sampled on accepted sof; 0 is illegal.
- lb_push_o  out  1  push to all line buffers.
- lb_pop_o  out  LB_N  per-buffer pop enable.
- lb_sof_o  out  1  sof to line buffers.
- lb_eol_o  out  1  eol to line buffers.
- win_vld_o  out  1  full KERNEL_H-tall column valid.
- win_col_o  out  CW  column index of win_vld_o.
- win_row_o  out  RW  row index of the bottom pixel of the column.
- win_sof_o  out  1  first window of frame.
- win_eol_o  out  1  last column of line.
- frame_done_o  out  1  one-cycle pulse, aligned with the final win_vld_o of a frame.
- err_o  out  1  sticky geometry error; cleared only by the next accepted sof.
- width_o  out  CW  measured line width minus 1 (valid after the first eol).

Behaviour:
- Reset: all outputs 0; state IDLE; counters, width, height and tag pipeline cleared. Reset mid-frame drops all in-flight windows: win_vld_o and frame_done_o are 0 from the cycle after reset is sampled.
- FSM states:
  - IDLE: beats without sof are dropped. Accepted sof → FILL; col=0, row=0, h=cfg_h_i, err cleared.
  - FILL: row < LB_N. On eol with row == LB_N-1 → RUN.
  - RUN: on eol with row == h-1 → IDLE.
  - ERR: drop all beats until sof, then behave as the IDLE sof case.
- acc = in_vld_i & (state in FILL/RUN, or in_sof_i).
- lb_push_o = acc.
- lb_sof_o = acc & in_sof_i.
- lb_eol_o = acc & in_eol_i.
- lb_pop_o[i] = acc & (row > i), with row saturating at LB_N for this compare. No pops are issued while line 0 is being written.
- Column counter: increments on each acc; resets to 0 after eol or sof. Row increments on acc & eol.
- Width: on the first eol of the frame (row 0), width = col. On later lines, an eol with col != width → error.
- Error conditions: any of the following sets err_o, enters ERR, and issues no further lb strobes:
  - col reaches IMAGE_MAX_W-1 without eol;
  - eol at the wrong column;
  - sof in FILL or RUN. A mid-frame sof is both the error beat and a fresh frame start: it is accepted, err_o is set, and the state goes to FILL, not ERR.
- Window tag pipe: stage 0 = acc & (row >= LB_N), with tags col, row, sof-of-window (row==LB_N & col==0), eol. Delayed exactly LB_LAT cycles to win_* outputs. frame_done_o = win_eol_o & (win_row_o == h-1).
- Entering ERR does not flush the tag pipe. Windows already issued retire normally; no new windows are issued.
- h == 0 or h <= LB_N: frame completes (returns to IDLE on the final eol), err_o set, no windows.
- Simultaneous sof & eol (1-pixel line): width=0; legal.

Test Plan:
- KERNEL_H=3, LB_LAT=2, cfg_h=4, 4-pixel lines, contiguous valid:
  - lb_pop_o=00 for pixels 0-3, 01 for pixels 4-7, 11 for pixels 8-15.
  - win_vld_o first high 2 cycles after pixel 8, with win_sof_o=1, col=0, row=2.
  - 8 windows total; frame_done_o pulses with the window at col=3, row=3.
- Same frame with in_vld_i toggling 1/0: identical strobe and window sequences, each window exactly 2 cycles after its accepted beat.
- Line 1 eol at col 2 (width 4): err_o=1, state ERR, lb_push_o=0 for remaining beats, no win_vld_o. Next sof clears err_o and frame 2 runs cleanly.
- sof injected at row 2, col 1: err_o=1, lb_sof_o=1 on that beat, row/col restart at 0, subsequent lb_pop_o=00 for 4 pixels.
- Reset asserted at row 3, col 1 with 2 windows in flight: win_vld_o=0 from the next cycle, all outputs 0, state IDLE. Non-sof beats after reset are dropped.
- cfg_h=2 with KERNEL_H=3: no win_vld_o, err_o=1 after the final eol, state returns to IDLE.

Source files
------------

// File: rtl/conv_lb_seq.sv
// Line-buffer sequencer for the conv datapath: turns the raw pixel stream into
// line-buffer push/pop strobes and a latency-matched, position-tagged window-valid.

package conv_pkg;
    localparam int IMAGE_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_ERR
    } seq_state_t;
endpackage

module conv_lb_seq #(
    parameter  int KERNEL_H    = 3,
    parameter  int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W,
    parameter  int IMAGE_MAX_H = 1024,
    parameter  int LB_LAT      = 2,
    localparam int LB_N        = KERNEL_H - 1,
    localparam int CW          = $clog2(IMAGE_MAX_W),
    localparam int RW          = $clog2(IMAGE_MAX_H)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            in_vld_i,
    input  logic            in_sof_i,
    input  logic            in_eol_i,
    input  logic [RW-1:0]   cfg_h_i,
    output logic            lb_push_o,
    output logic [LB_N-1:0] lb_pop_o,
    output logic            lb_sof_o,
    output logic            lb_eol_o,
    output logic            win_vld_o,
    output logic [CW-1:0]   win_col_o,
    output logic [RW-1:0]   win_row_o,
    output logic            win_sof_o,
    output logic            win_eol_o,
    output logic            frame_done_o,
    output logic            err_o,
    output logic [CW-1:0]   width_o
);
    import conv_pkg::*;

    typedef struct packed {
        logic          vld;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          sof;
        logic          eol;
        logic          last;
    } win_tag_t;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] col_q, width_q;
    logic [RW-1:0] row_q, h_q;
    logic          err_q;

    logic          active, acc;
    logic [CW-1:0] beat_col;
    logic [RW-1:0] beat_row, beat_h, last_row, row_sat;
    logic          is_last, col_ovf, eol_bad, geo_err, sof_mid, short_frame;

    win_tag_t      stage0;
    win_tag_t      pipe_q [LB_LAT];

    // A sof beat is pixel (0,0) of a fresh frame whatever the counters hold,
    // so every per-beat decision works on these "beat" views.
    assign active   = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign acc      = arst_n & in_vld_i & (active | in_sof_i);
    assign beat_col = in_sof_i ? '0 : col_q;
    assign beat_row = in_sof_i ? '0 : row_q;
    assign beat_h   = in_sof_i ? cfg_h_i : h_q;
    assign last_row = (beat_h == '0) ? '0 : beat_h - RW'(1);
    assign row_sat  = (beat_row >= RW'(LB_N)) ? RW'(LB_N) : beat_row;

    assign is_last     = in_eol_i & (beat_row == last_row);
    assign col_ovf     = ~in_eol_i & (beat_col == CW'(IMAGE_MAX_W - 1));
    assign eol_bad     = in_eol_i & (beat_row != '0) & (beat_col != width_q);
    assign geo_err     = acc & ~in_sof_i & (col_ovf | eol_bad);
    assign sof_mid     = acc & in_sof_i & active;
    assign short_frame = acc & is_last & ~geo_err & (beat_row < RW'(LB_N));

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the signal unassigned (latch).
        state_d = state_q;
        if (acc) begin
            if (geo_err) begin
                state_d = ST_ERR;
            end else if (is_last) begin
                state_d = ST_IDLE;
            end else if (in_eol_i && (beat_row == RW'(LB_N - 1))) begin
                state_d = ST_RUN;
            end else if (in_sof_i) begin
                state_d = ST_FILL;
            end
        end
    end

    always_comb begin
        lb_push_o = acc;
        lb_sof_o  = acc & in_sof_i;
        lb_eol_o  = acc & in_eol_i;
        lb_pop_o  = '0;
        for (int i = 0; i < LB_N; i++) begin
            lb_pop_o[i] = acc & (row_sat > RW'(i));
        end

        // A malformed beat is still written to the buffers but never forms a window.
        stage0 = '0;
        if (acc && !geo_err && (beat_row >= RW'(LB_N))) begin
            stage0.vld  = 1'b1;
            stage0.col  = beat_col;
            stage0.row  = beat_row;
            stage0.sof  = (beat_row == RW'(LB_N)) && (beat_col == '0);
            stage0.eol  = in_eol_i;
            stage0.last = is_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            width_q <= '0;
            err_q   <= 1'b0;
        end else if (acc) begin
            col_q <= in_eol_i ? '0 : beat_col + CW'(1);
            row_q <= in_eol_i ? beat_row + RW'(1) : beat_row;
            if (in_sof_i) begin
                h_q <= cfg_h_i;
            end
            if (in_eol_i && (beat_row == '0)) begin
                width_q <= beat_col;
            end
            // A sof clears the sticky error unless that same beat is itself an error.
            if (in_sof_i) begin
                err_q <= sof_mid | short_frame;
            end else if (geo_err || short_frame) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            // NOTE: this small tag pipe is reset on purpose so a reset drops every in-flight window.
            for (int i = 0; i < LB_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage0;
            for (int i = 1; i < LB_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign win_vld_o    = pipe_q[LB_LAT-1].vld;
    assign win_col_o    = pipe_q[LB_LAT-1].col;
    assign win_row_o    = pipe_q[LB_LAT-1].row;
    assign win_sof_o    = pipe_q[LB_LAT-1].sof;
    assign win_eol_o    = pipe_q[LB_LAT-1].eol;
    assign frame_done_o = pipe_q[LB_LAT-1].vld & pipe_q[LB_LAT-1].eol & pipe_q[LB_LAT-1].last;
    assign err_o        = err_q;
    assign width_o      = width_q;

endmodule
